// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: stall/flush interlock for the 5-stage LEGv8 pipeline.
// Catches the operand hazards that EX-stage forwarding cannot hide (load-use, CBZ operand
// dependence), flushes IFID on a taken branch and freezes the whole pipe on a data-memory
// wait. Define STALL_PERF_CNT_EN to add the stall_cycles / flush_count counters.
module hazard_stall_ctrl #(
  parameter int unsigned ZERO_REG    = 31,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rn,
  input  logic [4:0]       ifid_rm,
  input  logic [4:0]       ifid_rd,
  input  logic             ifid_uses_rn,
  input  logic             ifid_uses_rm,
  input  logic             ifid_is_store,
  input  logic             ifid_is_cbz,
  input  logic             idex_regwrite,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_memread,
  input  logic [4:0]       exmem_rd,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             pipe_freeze,
`ifdef STALL_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
`endif
  output logic             mem_timeout
);

  // Wait counter is at least 8 bits, wider only if MEM_TIMEOUT needs it.
  localparam int unsigned WaitW = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);
  localparam logic [WaitW-1:0] TimeoutM1  = WaitW'(MEM_TIMEOUT - 1);
  localparam logic [4:0]       ZeroReg    = 5'(ZERO_REG);

  if (MEM_TIMEOUT == 0 || CNT_W == 0) begin : gen_param_check
    $error("hazard_stall_ctrl: MEM_TIMEOUT and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StStall   = 2'd1,
    StMemWait = 2'd2
  } state_e;

  state_e           state_q, state_d;
  state_e           saved_q, saved_d;   // state to resume once the memory wait ends
  logic [1:0]       scnt_q, scnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  logic       rd_read;
  logic       idex_rd_nz;
  logic       exmem_rd_nz;
  logic       idex_match;
  logic       cbz_idex;
  logic       cbz_exmem;
  logic [1:0] need;
  logic       freeze;
  logic       flush_now;
  state_e     eff_state;
  logic       stall_now;

  // Source matching. XZR reads as zero and is never written, so it never creates a hazard.
  assign rd_read     = ifid_is_store | ifid_is_cbz;
  assign idex_rd_nz  = (idex_rd != ZeroReg);
  assign exmem_rd_nz = (exmem_rd != ZeroReg);
  assign idex_match  = idex_rd_nz &
                       ((ifid_uses_rn & (idex_rd == ifid_rn)) |
                        (ifid_uses_rm & (idex_rd == ifid_rm)) |
                        (rd_read      & (idex_rd == ifid_rd)));
  assign cbz_idex    = ifid_is_cbz & idex_rd_nz  & (idex_rd == ifid_rd);
  assign cbz_exmem   = ifid_is_cbz & exmem_rd_nz & (exmem_rd == ifid_rd);

  // Required stall count: the largest of all hazard rules that fire.
  always_comb begin
    need = 2'd0;
    if ((idex_memread & idex_match) ||
        (cbz_idex & idex_regwrite & !idex_memread) ||
        (cbz_exmem & exmem_memread)) begin
      need = 2'd1;
    end
    // CBZ resolves in ID, so a load feeding it must reach WB first.
    if (cbz_idex & idex_memread) begin
      need = 2'd2;
    end
  end

  assign freeze    = mem_req & !mem_ready;
  assign flush_now = branch_taken & !freeze;

  // Once the wait clears, the interlock carries on exactly where it was frozen.
  assign eff_state = (state_q == StMemWait) ? saved_q : state_q;

  // Last STALL cycle (scnt==0) releases the held instruction; all its bubbles are already in.
  assign stall_now = ((eff_state == StRun) && (need != 2'd0)) ||
                     ((eff_state == StStall) && (scnt_q != 2'd0));

  // Next-state logic: freeze > branch flush > stall.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    scnt_d  = scnt_q;
    if (freeze) begin
      state_d = StMemWait;
      if (state_q != StMemWait) begin
        saved_d = state_q;
      end
    end else if (branch_taken) begin
      // Taken branch squashes whatever was being stalled.
      state_d = StRun;
      scnt_d  = 2'd0;
    end else if (eff_state == StRun) begin
      if (need != 2'd0) begin
        state_d = StStall;
        scnt_d  = need - 2'd1;
      end else begin
        state_d = StRun;
      end
    end else begin
      if (scnt_q == 2'd0) begin
        state_d = StRun;
      end else begin
        state_d = StStall;
        scnt_d  = scnt_q - 2'd1;
      end
    end
  end

  // Consecutive wait-cycle counter and sticky timeout flag.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    if (freeze) begin
      if (wait_cnt_q != TimeoutVal) begin
        wait_cnt_d = wait_cnt_q + WaitW'(1);
      end
      if (wait_cnt_q >= TimeoutM1) begin
        timeout_d = 1'b1;
      end
    end else begin
      wait_cnt_d = '0;
    end
  end

  // Pipeline control outputs; reset forces a flushed, non-advancing pipe.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end else if (freeze) begin
      pipe_freeze = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall_now) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign mem_timeout = rst_n & timeout_q;

  // State, stall counter, saved state and wait tracking registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      saved_q    <= StRun;
      scnt_q     <= 2'd0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      scnt_q     <= scnt_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating perf counters: real stall bubbles and taken-branch flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (idex_bubble && !ifid_flush && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_now && !(&flush_cnt_q)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  // Perf counters are compiled out; flush_now is only needed by them.
  logic unused_flush_now;
  assign unused_flush_now = flush_now;
`endif

endmodule
